// File: rtl/alarm_trigger_if.sv
// Alarm trigger signal bundle: time/alarm inputs, buttons, ms tick and buzzer/snooze status.
// The master side drives the inputs; the slave (alarm_trigger) drives the status outputs.
interface alarm_trigger_if;
    logic       msTick;
    logic [4:0] curHour;
    logic [5:0] curMin;
    logic [4:0] alarmHour;
    logic [5:0] alarmMin;
    logic       alarmEn;
    logic       snoozeBtn;
    logic       stopBtn;
    logic       tobuzzer;
    logic       snoozing;
    logic [1:0] snoozeCnt;

    modport master (
        output msTick, curHour, curMin, alarmHour, alarmMin, alarmEn, snoozeBtn, stopBtn,
        input  tobuzzer, snoozing, snoozeCnt
    );

    modport slave (
        input  msTick, curHour, curMin, alarmHour, alarmMin, alarmEn, snoozeBtn, stopBtn,
        output tobuzzer, snoozing, snoozeCnt
    );
endinterface

// File: rtl/alarm_trigger.sv
// Alarm sequencer: rings on a time match, supports bounded snoozes, and times out
// both snooze and ring periods with a ms/second down-stream counter pair.
//
// state   | meaning
// IDLE    | armed, waiting for a time match
// RINGING | buzzer requested, ring timeout running
// SNOOZE  | buzzer silent, snooze timer running
// DONE    | event finished, waiting for the match minute to pass
module alarm_trigger #(
    parameter int SNOOZE_S   = 540,
    parameter int RING_S     = 300,
    parameter int MAX_SNOOZE = 3
) (
    input  logic          uclock,
    input  logic          resetn,
    alarm_trigger_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [9:0] MS_LAST     = 10'd999;
    localparam logic [9:0] SEC_MAX     = 10'd1023;
    localparam logic [9:0] SNOOZE_LAST = 10'(SNOOZE_S - 1);
    localparam logic [9:0] RING_LAST   = 10'(RING_S - 1);
    localparam logic [1:0] SNOOZE_LIM  = 2'(MAX_SNOOZE);

    state_t     state, state_nxt;
    logic [1:0] snooze_cnt, snooze_cnt_nxt;
    logic [9:0] ms_cnt, sec_cnt;
    logic       snooze_hist, stop_hist;
    logic       buzz_q, snoozing_q;
    logic       match, snooze_press, stop_press;
    logic       sec_wrap, ring_expired, snooze_expired;
    logic       timed_nxt, entering;

    assign match          = bus.alarmEn && (bus.curHour == bus.alarmHour) && (bus.curMin == bus.alarmMin);
    assign snooze_press   = bus.snoozeBtn && !snooze_hist;
    assign stop_press     = bus.stopBtn && !stop_hist;
    assign sec_wrap       = bus.msTick && (ms_cnt == MS_LAST);
    assign ring_expired   = sec_wrap && (sec_cnt == RING_LAST);
    assign snooze_expired = sec_wrap && (sec_cnt == SNOOZE_LAST);

    // Stop beats snooze and timer expiry; a snooze press beats a coincident ring timeout.
    always_comb begin
        state_nxt      = state;
        snooze_cnt_nxt = snooze_cnt;
        if (!bus.alarmEn) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (match) begin
                        state_nxt      = RINGING;
                        snooze_cnt_nxt = 2'd0;
                    end
                end
                RINGING: begin
                    if (stop_press) begin
                        state_nxt = DONE;
                    end else if (snooze_press && (snooze_cnt < SNOOZE_LIM)) begin
                        state_nxt      = SNOOZE;
                        snooze_cnt_nxt = snooze_cnt + 2'd1;
                    end else if (ring_expired) begin
                        state_nxt = DONE;
                    end
                end
                SNOOZE: begin
                    if (stop_press) begin
                        state_nxt = DONE;
                    end else if (snooze_expired) begin
                        state_nxt = RINGING;
                    end
                end
                DONE: begin
                    if (!match) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign timed_nxt = (state_nxt == RINGING) || (state_nxt == SNOOZE);
    assign entering  = timed_nxt && (state_nxt != state);

    always_ff @(posedge uclock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            snooze_cnt  <= 2'd0;
            buzz_q      <= 1'b0;
            snoozing_q  <= 1'b0;
            snooze_hist <= 1'b1;
            stop_hist   <= 1'b1;
        end else begin
            state       <= state_nxt;
            snooze_cnt  <= snooze_cnt_nxt;
            buzz_q      <= (state_nxt == RINGING);
            snoozing_q  <= (state_nxt == SNOOZE);
            snooze_hist <= bus.snoozeBtn;
            stop_hist   <= bus.stopBtn;
        end
    end

    always_ff @(posedge uclock or negedge resetn) begin
        if (!resetn) begin
            ms_cnt  <= 10'd0;
            sec_cnt <= 10'd0;
        end else if (entering || !timed_nxt) begin
            ms_cnt  <= 10'd0;
            sec_cnt <= 10'd0;
        end else if (bus.msTick) begin
            if (ms_cnt == MS_LAST) begin
                ms_cnt <= 10'd0;
                if (sec_cnt != SEC_MAX) begin
                    sec_cnt <= sec_cnt + 10'd1;
                end
            end else begin
                ms_cnt <= ms_cnt + 10'd1;
            end
        end
    end

    assign bus.tobuzzer  = buzz_q;
    assign bus.snoozing  = snoozing_q;
    assign bus.snoozeCnt = snooze_cnt;
endmodule

// File: tb/tb_alarm_trigger.sv
// Self-checking bench for alarm_trigger: directed alarm scenarios followed by
// randomized traffic, compared each cycle against an elapsed-time reference model.
module tb_alarm_trigger;
    localparam int SNOOZE_S   = 2;
    localparam int RING_S     = 3;
    localparam int MAX_SNOOZE = 3;
    localparam int SNOOZE_MS  = SNOOZE_S * 1000;
    localparam int RING_MS    = RING_S * 1000;

    localparam int M_IDLE   = 0;
    localparam int M_RING   = 1;
    localparam int M_SNOOZE = 2;
    localparam int M_DONE   = 3;

    logic uclock = 1'b0;
    logic resetn = 1'b0;

    alarm_trigger_if bus();

    alarm_trigger #(
        .SNOOZE_S  (SNOOZE_S),
        .RING_S    (RING_S),
        .MAX_SNOOZE(MAX_SNOOZE)
    ) dut (
        .uclock(uclock),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 uclock = ~uclock;

    int n_cmp = 0;
    int n_bad = 0;

    int m_mode;
    int m_used;
    int m_elapsed;
    bit m_hist_snz;
    bit m_hist_stp;

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        n_cmp++;
        if (got !== 32'(exp)) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode     = M_IDLE;
        m_used     = 0;
        m_elapsed  = 0;
        m_hist_snz = 1'b1;
        m_hist_stp = 1'b1;
    endtask

    // One clock of the alarm rules, using elapsed milliseconds since entering a timed mode.
    task automatic model_clock();
        bit ps, pt, match, tick;
        ps    = bus.snoozeBtn && !m_hist_snz;
        pt    = bus.stopBtn && !m_hist_stp;
        tick  = bus.msTick;
        match = bus.alarmEn && (bus.curHour == bus.alarmHour) && (bus.curMin == bus.alarmMin);
        if (!bus.alarmEn) begin
            m_mode = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            if (match) begin
                m_mode = M_RING; m_used = 0; m_elapsed = 0;
            end
        end else if (m_mode == M_RING) begin
            if (pt) m_mode = M_DONE;
            else if (ps && m_used < MAX_SNOOZE) begin
                m_mode = M_SNOOZE; m_used++; m_elapsed = 0;
            end else if (tick) begin
                m_elapsed++;
                if (m_elapsed == RING_MS) m_mode = M_DONE;
            end
        end else if (m_mode == M_SNOOZE) begin
            if (pt) m_mode = M_DONE;
            else if (tick) begin
                m_elapsed++;
                if (m_elapsed == SNOOZE_MS) begin
                    m_mode = M_RING; m_elapsed = 0;
                end
            end
        end else begin
            if (!match) m_mode = M_IDLE;
        end
        m_hist_snz = bus.snoozeBtn;
        m_hist_stp = bus.stopBtn;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_buzz"}, 32'(bus.tobuzzer), int'(m_mode == M_RING));
        chk({tag, "_snz"},  32'(bus.snoozing), int'(m_mode == M_SNOOZE));
        chk({tag, "_cnt"},  32'(bus.snoozeCnt), m_used);
    endtask

    task automatic step();
        @(posedge uclock);
        if (resetn) model_clock();
        else model_reset();
        #1;
        check_outputs("cyc");
    endtask

    task automatic ticks(input int n);
        bus.msTick = 1'b1;
        repeat (n) step();
        bus.msTick = 1'b0;
    endtask

    task automatic press_snooze();
        bus.snoozeBtn = 1'b1;
        step();
        bus.snoozeBtn = 1'b0;
    endtask

    initial begin
        bus.alarmHour = 5'd7;
        bus.alarmMin  = 6'd30;
        bus.curHour   = 5'd7;
        bus.curMin    = 6'd29;
        bus.alarmEn   = 1'b1;
        bus.snoozeBtn = 1'b0;
        bus.stopBtn   = 1'b0;
        bus.msTick    = 1'b0;
        model_reset();
        #2;
        chk("rst_buzz", 32'(bus.tobuzzer), 0);
        chk("rst_snz",  32'(bus.snoozing), 0);
        chk("rst_cnt",  32'(bus.snoozeCnt), 0);
        repeat (2) step();
        resetn = 1'b1;
        repeat (2) step();

        // 07:29 -> 07:30 triggers on the next edge
        bus.curMin = 6'd30;
        step();
        chk("trig_buzz", 32'(bus.tobuzzer), 1);
        chk("trig_cnt",  32'(bus.snoozeCnt), 0);

        press_snooze();
        chk("snz1_buzz", 32'(bus.tobuzzer), 0);
        chk("snz1_snz",  32'(bus.snoozing), 1);
        chk("snz1_cnt",  32'(bus.snoozeCnt), 1);
        ticks(SNOOZE_MS - 1);
        chk("snz1_hold", 32'(bus.snoozing), 1);
        ticks(1);
        chk("snz1_rering", 32'(bus.tobuzzer), 1);

        // Time/alarm changes while snoozing must not matter
        for (int k = 2; k <= 3; k++) begin
            press_snooze();
            chk("snz_cnt", 32'(bus.snoozeCnt), k);
            bus.curMin    = 6'd45;
            bus.alarmHour = 5'd3;
            ticks(SNOOZE_MS);
            bus.curMin    = 6'd30;
            bus.alarmHour = 5'd7;
            chk("rering", 32'(bus.tobuzzer), 1);
        end

        press_snooze();
        chk("snz_max_cnt",  32'(bus.snoozeCnt), 3);
        chk("snz_max_buzz", 32'(bus.tobuzzer), 1);

        ticks(RING_MS - 1);
        chk("ring_before_to", 32'(bus.tobuzzer), 1);
        ticks(1);
        chk("ring_timeout", 32'(bus.tobuzzer), 0);
        repeat (5) step();
        chk("done_hold", 32'(bus.tobuzzer), 0);
        bus.curMin = 6'd31;
        step();
        bus.curMin = 6'd30;
        step();
        chk("new_event_buzz", 32'(bus.tobuzzer), 1);
        chk("new_event_cnt",  32'(bus.snoozeCnt), 0);

        // Stop and snooze together: stop wins, count untouched
        press_snooze();
        ticks(SNOOZE_MS);
        bus.snoozeBtn = 1'b1;
        bus.stopBtn   = 1'b1;
        step();
        chk("both_buzz", 32'(bus.tobuzzer), 0);
        chk("both_snz",  32'(bus.snoozing), 0);
        chk("both_cnt",  32'(bus.snoozeCnt), 1);
        bus.snoozeBtn = 1'b0;
        bus.stopBtn   = 1'b0;
        step();

        // Disarm while snoozing
        bus.curMin = 6'd31;
        step();
        bus.curMin = 6'd30;
        step();
        press_snooze();
        bus.alarmEn = 1'b0;
        step();
        chk("dis_snz",  32'(bus.snoozing), 0);
        chk("dis_buzz", 32'(bus.tobuzzer), 0);
        chk("dis_cnt",  32'(bus.snoozeCnt), 1);
        bus.alarmEn = 1'b1;
        step();
        chk("rearm_buzz", 32'(bus.tobuzzer), 1);

        // Async reset mid-snooze with stop held through release
        press_snooze();
        chk("pre_rst_snz", 32'(bus.snoozing), 1);
        #2;
        bus.stopBtn = 1'b1;
        resetn      = 1'b0;
        model_reset();
        #1;
        chk("arst_buzz", 32'(bus.tobuzzer), 0);
        chk("arst_snz",  32'(bus.snoozing), 0);
        chk("arst_cnt",  32'(bus.snoozeCnt), 0);
        repeat (2) step();
        resetn = 1'b1;
        step();
        chk("rst_retrig", 32'(bus.tobuzzer), 1);
        step();
        chk("rst_no_stop", 32'(bus.tobuzzer), 1);
        bus.stopBtn = 1'b0;
        step();

        // Randomized traffic
        for (int i = 0; i < 40000; i++) begin
            if ($urandom_range(0, 59) == 0) bus.snoozeBtn = ~bus.snoozeBtn;
            if ($urandom_range(0, 399) == 0) bus.stopBtn = ~bus.stopBtn;
            bus.msTick = ($urandom_range(0, 3) != 0);
            if (bus.alarmEn && $urandom_range(0, 2999) == 0) bus.alarmEn = 1'b0;
            else if (!bus.alarmEn && $urandom_range(0, 9) == 0) bus.alarmEn = 1'b1;
            if ($urandom_range(0, 299) == 0) bus.curMin = 6'($urandom_range(28, 32));
            if ($urandom_range(0, 1999) == 0) bus.curHour = 5'($urandom_range(6, 8));
            if ($urandom_range(0, 9999) == 0) begin
                resetn = 1'b0;
                model_reset();
                #1;
                check_outputs("rnd_rst");
                resetn = 1'b1;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
